// File: rtl/counter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// counter_rr_arbiter
//
// Shares one WIDTH-bit event counter among NREQ requesters. A round-robin
// arbiter picks at most one requester per clock. The winner gets a one-cycle
// registered grant pulse, and the counter increments on that same edge.
// A synchronous clear has priority over any increment. Two sticky flags are
// kept: hit (an increment landed on i_limit) and ovf (an increment was
// attempted at all-ones). WRAP selects whether the counter wraps or saturates
// on overflow.
//
// Ports:
//   i_clk      system clock, all state updates on posedge
//   i_reset_n  asynchronous active-low reset, clears all state
//   i_req      per-requester level request, held until granted
//   i_clr      synchronous clear of count/hit/ovf, blocks grants that cycle
//   i_limit    compare value for the hit flag
//   o_gnt      one-hot registered grant pulse, one cycle wide
//   o_last_id  index of the most recently granted requester
//   o_count    current counter value
//   o_hit      sticky: an increment produced count == i_limit
//   o_ovf      sticky: an increment was attempted at all-ones
//   o_busy     combinational: some requester is still waiting
// -----------------------------------------------------------------------------
module counter_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int WRAP  = 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [NREQ-1:0]         i_req,
  input  logic                    i_clr,
  input  logic [WIDTH-1:0]        i_limit,
  output logic [NREQ-1:0]         o_gnt,
  output logic [$clog2(NREQ)-1:0] o_last_id,
  output logic [WIDTH-1:0]        o_count,
  output logic                    o_hit,
  output logic                    o_ovf,
  output logic                    o_busy
);

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]  r_gnt;
  logic [IW-1:0]    r_last_id;
  logic [IW-1:0]    r_ptr;
  logic [WIDTH-1:0] r_count;
  logic             r_hit;
  logic             r_ovf;

  logic [NREQ-1:0]  w_elig;
  logic [IW-1:0]    w_idx;
  logic [IW-1:0]    w_win;
  logic [IW-1:0]    w_ptr_nxt;
  logic             w_any;
  logic [WIDTH:0]   w_inc;

  // Next counter value with overflow handling. Returns {overflow, next_count}.
  function automatic logic [WIDTH:0] f_inc(input logic [WIDTH-1:0] v);
    if (&v) begin
      if (WRAP != 0) return {1'b1, {WIDTH{1'b0}}};
      else           return {1'b1, v};
    end
    return {1'b0, v + 1'b1};
  endfunction

  // A requester whose grant bit is currently high is dropping its request this
  // cycle, so it is masked out; a request still high next cycle is a new one.
  always_comb begin
    w_elig = i_req & ~r_gnt;
    w_any  = 1'b0;
    w_win  = '0;
    w_idx  = '0;
    // Walk from the farthest offset down to ptr so the nearest set bit wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = IW'((int'(r_ptr) + k) % NREQ);
      if (w_elig[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_ptr_nxt = (w_win == IW'(NREQ - 1)) ? '0 : w_win + 1'b1;
  assign w_inc     = f_inc(r_count);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_gnt     <= '0;
      r_last_id <= '0;
      r_ptr     <= '0;
      r_count   <= '0;
      r_hit     <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (i_clr) begin
      // Pending requests are untouched and get served once clear drops.
      r_gnt   <= '0;
      r_count <= '0;
      r_hit   <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_any) begin
      r_gnt     <= NREQ'(1) << w_win;
      r_last_id <= w_win;
      r_ptr     <= w_ptr_nxt;
      r_count   <= w_inc[WIDTH-1:0];
      if (w_inc[WIDTH])
        r_ovf <= 1'b1;
      if (w_inc[WIDTH-1:0] == i_limit)
        r_hit <= 1'b1;
    end else begin
      r_gnt <= '0;
    end
  end

  assign o_gnt     = r_gnt;
  assign o_last_id = r_last_id;
  assign o_count   = r_count;
  assign o_hit     = r_hit;
  assign o_ovf     = r_ovf;
  assign o_busy    = |(i_req & ~r_gnt);

endmodule

// File: tb/tb_counter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_counter_rr_arbiter
//
// Directed bench for counter_rr_arbiter. Two instances share all inputs: u_dut
// wraps on overflow, u_sat saturates. Inputs change and outputs are sampled
// 1 ns after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_counter_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;

  logic             clk;
  logic             reset_n;
  logic [NREQ-1:0]  req;
  logic             clr;
  logic [WIDTH-1:0] limit;

  logic [NREQ-1:0]  gnt,     s_gnt;
  logic [1:0]       last_id, s_last_id;
  logic [WIDTH-1:0] count,   s_count;
  logic             hit,     s_hit;
  logic             ovf,     s_ovf;
  logic             busy,    s_busy;

  int n_tests = 0;
  int n_fail  = 0;

  counter_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .WRAP(1)) u_dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_req(req), .i_clr(clr), .i_limit(limit),
    .o_gnt(gnt), .o_last_id(last_id), .o_count(count), .o_hit(hit),
    .o_ovf(ovf), .o_busy(busy)
  );

  counter_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .WRAP(0)) u_sat (
    .i_clk(clk), .i_reset_n(reset_n), .i_req(req), .i_clr(clr), .i_limit(limit),
    .o_gnt(s_gnt), .o_last_id(s_last_id), .o_count(s_count), .o_hit(s_hit),
    .o_ovf(s_ovf), .o_busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    req     = 4'hF;
    clr     = 1'b0;
    limit   = 16'd0;

    // Reset held with all requests high
    tick(); tick();
    chk("rst_gnt",   gnt,   4'b0000);
    chk("rst_count", count, 16'd0);
    chk("rst_hit",   hit,   1'b0);
    chk("rst_ovf",   ovf,   1'b0);
    chk("rst_busy",  busy,  1'b1);
    chk("rst_last",  last_id, 2'd0);

    // Release: all four served in order 0..3, each dropping on its grant
    reset_n = 1'b1;
    tick();
    chk("rr_g0", gnt, 4'b0001); chk("rr_c1", count, 16'd1);
    req = 4'b1110;
    tick();
    chk("rr_g1", gnt, 4'b0010); chk("rr_c2", count, 16'd2);
    req = 4'b1100;
    tick();
    chk("rr_g2", gnt, 4'b0100); chk("rr_c3", count, 16'd3);
    req = 4'b1000;
    tick();
    chk("rr_g3", gnt, 4'b1000); chk("rr_c4", count, 16'd4);
    chk("rr_last3", last_id, 2'd3);
    req = 4'b0000;
    chk("rr_busy0", busy, 1'b0);
    tick();
    chk("rr_idle_gnt", gnt, 4'b0000); chk("rr_idle_cnt", count, 16'd4);

    // Clear, then three separate pulses of req[2]
    clr = 1'b1;
    tick();
    chk("clr_cnt", count, 16'd0); chk("clr_gnt", gnt, 4'b0000);
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req = 4'b0100;
      tick();
      chk("p2_gnt", gnt, 4'b0100);
      req = 4'b0000;
      tick();
      chk("p2_gnt_off", gnt, 4'b0000);
    end
    chk("p2_count", count, 16'd3);
    chk("p2_last",  last_id, 2'd2);

    // Make last_id=1 (ptr -> 2), then req=1011 gives order 3, 0, 1
    req = 4'b0010;
    tick();
    chk("l1_gnt",  gnt, 4'b0010);
    chk("l1_last", last_id, 2'd1);
    req = 4'b0000;
    tick();
    req = 4'b1011;
    tick();
    chk("o_g3", gnt, 4'b1000);
    req = 4'b0011;
    tick();
    chk("o_g0", gnt, 4'b0001);
    req = 4'b0010;
    tick();
    chk("o_g1", gnt, 4'b0010);
    req = 4'b0000;
    tick();
    chk("o_count", count, 16'd7);

    // Clear in the same cycle as req[0]: clear wins, request served next
    clr = 1'b1; req = 4'b0001;
    tick();
    chk("cp_gnt",  gnt, 4'b0000);
    chk("cp_cnt",  count, 16'd0);
    chk("cp_last", last_id, 2'd1);
    clr = 1'b0;
    tick();
    chk("cp_gnt2", gnt, 4'b0001);
    chk("cp_cnt2", count, 16'd1);
    req = 4'b0000;
    tick();

    // Hit at limit 5, sticky through 6, not cleared by a limit change
    limit = 16'd5;
    req = 4'hF;
    tick(); chk("h_c2", count, 16'd2);
    tick(); chk("h_c3", count, 16'd3);
    tick(); chk("h_c4", count, 16'd4); chk("h_pre", hit, 1'b0);
    tick(); chk("h_c5", count, 16'd5); chk("h_set", hit, 1'b1);
    tick(); chk("h_c6", count, 16'd6); chk("h_hold", hit, 1'b1);
    req = 4'b0000;
    limit = 16'd100;
    tick();
    chk("h_lim_chg", hit, 1'b1);
    clr = 1'b1;
    tick();
    chk("h_clr", hit, 1'b0); chk("h_clr_cnt", count, 16'd0);
    clr = 1'b0;

    // Reset while a grant to requester 2 is in flight
    req = 4'b0100;
    tick();
    chk("mr_gnt", gnt, 4'b0100); chk("mr_cnt", count, 16'd1);
    reset_n = 1'b0;
    req = 4'b1010;
    #1;
    chk("mr_gnt0", gnt, 4'b0000);
    chk("mr_cnt0", count, 16'd0);
    chk("mr_last0", last_id, 2'd0);
    tick();
    chk("mr_hold", gnt, 4'b0000);
    reset_n = 1'b1;
    tick();
    chk("mr_first", gnt, 4'b0010);
    chk("mr_cnt1",  count, 16'd1);
    req = 4'b0000;
    tick();

    // Preload to all-ones with back-to-back grants, limit 0
    limit = 16'd0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    req = 4'hF;
    for (int i = 0; i < 65535; i++) tick();
    chk("pl_cnt_w", count,   16'hFFFF);
    chk("pl_cnt_s", s_count, 16'hFFFF);
    chk("pl_ovf_w", ovf,     1'b0);
    chk("pl_hit_w", hit,     1'b0);

    // One more grant: wrap vs saturate
    tick();
    chk("ov_cnt_w", count,   16'h0000);
    chk("ov_ovf_w", ovf,     1'b1);
    chk("ov_hit_w", hit,     1'b1);
    chk("ov_gnt_w", gnt,     4'b0010);
    chk("ov_cnt_s", s_count, 16'hFFFF);
    chk("ov_ovf_s", s_ovf,   1'b1);
    chk("ov_hit_s", s_hit,   1'b0);
    chk("ov_gnt_s", s_gnt,   4'b0010);
    chk("ov_last",  last_id, 2'd1);
    tick();
    chk("ov2_cnt_w", count,   16'd1);
    chk("ov2_ovf_w", ovf,     1'b1);
    chk("ov2_cnt_s", s_count, 16'hFFFF);
    chk("ov2_gnt_s", s_gnt,   4'b0100);
    req = 4'b0000;
    chk("ov2_busy_s", s_busy, 1'b0);
    clr = 1'b1;
    tick();
    chk("fin_ovf_w", ovf,   1'b0);
    chk("fin_ovf_s", s_ovf, 1'b0);
    chk("fin_cnt_s", s_count, 16'd0);
    clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_rr_arbiter.md
Name: counter_rr_arbiter

Overview:
- Shares one WIDTH-bit event counter among NREQ requesters, such as debounced buttons or FSM event strobes.
- Round-robin arbitration grants at most one increment per clock and acknowledges each requester with a one-cycle grant pulse.
- Also provides a prioritised synchronous clear, a programmable limit-hit flag and wrap/saturate overflow handling.
- Sits between the event sources and the seven-segment/LED display path, which reads count.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 16, counter width.
- WRAP, 1, overflow policy: 1 = wrap to 0, 0 = saturate at all-ones.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (reset==0 clears all state immediately).
- req  input  NREQ  per-requester increment request, level, held until granted.
- clr  input  1  synchronous clear request, sampled on posedge.
- limit  input  WIDTH  compare value for hit.
- gnt  output  NREQ  one-hot registered grant pulse; the bit is high for exactly one cycle.
- last_id  output  $clog2(NREQ)  index of the most recently granted requester.
- count  output  WIDTH  current counter value.
- hit  output  1  sticky: count reached limit via an increment.
- ovf  output  1  sticky: increment attempted at all-ones.
- busy  output  1  combinational |(req & ~gnt).

Behaviour:
- Reset (reset==0, asynchronous): count=0, gnt=0, last_id=0, hit=0, ovf=0, RR pointer ptr=0. Outputs hold these values while reset is low.
- Eligibility: elig = req & ~gnt. A requester that sees its gnt bit must drop req in that same cycle. If req is still high one cycle after gnt, it counts as a new request.
- Arbitration (combinational, each cycle): search elig starting at index ptr, ascending modulo NREQ. The first set bit is the winner w.
- Grant cycle (clr==0, elig!=0), on the posedge:
  - gnt <= onehot(w); last_id <= w; ptr <= (w+1) mod NREQ.
  - count <= count+1, subject to the overflow rule below.
- No eligible request, or clr==1: gnt <= 0; ptr and last_id are unchanged.
- Latency: req rising before edge k gives gnt high in cycle k..k+1. count reflects the increment from that same edge k.
- Throughput: one increment per clock; N simultaneous requesters are all served within N cycles.
- Clear:
  - clr==1 at an edge: count <= 0, hit <= 0, ovf <= 0, no grant is issued.
  - Pending requests stay pending and are served after clr drops.
  - clr has priority over increment in the same cycle.
- Overflow (count==all-ones and a grant occurs):
  - WRAP=1: count <= 0, ovf <= 1.
  - WRAP=0: count stays all-ones, ovf <= 1.
  - In both cases the grant is still issued.
- Hit:
  - hit <= 1 on an edge where a grant occurs and the next count value == limit. Sticky until clr or reset.
  - limit==0 sets hit only when a wrap produces 0.
  - A change of limit does not set or clear hit.
- Reset asserted mid-operation: all state clears at once, including any in-flight gnt. Requesters whose req is still high are re-arbitrated from ptr=0 after reset releases.
- No internal FSM beyond ptr; the design is purely registered, with no combinational path from req to gnt.

Test Plan:
- Reset low with req=4'hF -> gnt=0, count=0, hit=0, ovf=0, busy=1. Release reset -> first grant is gnt=4'b0001, count=1.
- req[2] pulsed three separate times, each held until gnt -> three single-cycle gnt=4'b0100 pulses, count=3, last_id=2.
- req=4'hF held, each bit dropped on its own grant -> grants in cycles 1..4 are 0001, 0010, 0100, 1000; count=4; busy=0 afterwards.
- After last_id=1, req=4'b1011 -> grant order 3, then 0, then 1.
- clr asserted in the same cycle as req[0] -> no gnt, count=0. The next cycle gives gnt=0001, count=1.
- count preloaded to 16'hFFFF via grants:
  - WRAP=1, one more grant -> count=0, ovf=1.
  - WRAP=0 -> count stays 16'hFFFF, ovf=1, gnt still pulses.
- limit=5 -> hit rises on the edge where count becomes 5 and stays high through count=6. clr -> hit=0.
- reset pulled low while gnt=0100 -> gnt=0 and count=0 immediately. After release, the first grant goes to the lowest-index active requester.
